fpu_lnormalizer: RTL and testbench

- Pipelined left-shift normalizer for the FPU datapath; counterpart of the alignment right shifter on the result side.
- Takes an unnormalized mantissa plus biased exponent, counts leading zeros, shifts left so the MSB is set, and decrements the exponent.
- When the exponent cannot absorb the full shift, it clamps the shift and emits a denormal result.
- Sits between the mantissa add/sub stage and the rounder, with valid/ready handshakes on both sides.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fpu_lshifter.sv | 34 +++
 rtl/fpu_lnormalizer.sv | 155 +++++++++++++++
 tb/tb_fpu_lnormalizer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU datapath blocks.
//   FPU_WIDTH  default mantissa width (power of two)
//   FPU_EXP_W  default biased exponent width
//   FPU_SH_W   default shift/count width, clog2(FPU_WIDTH)+1 so that a count
//              equal to the full width is representable
//   count_lz() leading-zero counter shared by the normalizer and the rounder
// -----------------------------------------------------------------------------
package fpu_pkg;

   localparam int FPU_WIDTH = 32;
   localparam int FPU_EXP_W = 8;
   localparam int FPU_SH_W  = 6;

   // Widest vector count_lz() can inspect; callers zero-extend into this.
   localparam int LZC_MAX_W = 64;

   // Counts leading zeros of the low 'w' bits of d, returning w when those
   // bits are all zero. The scan runs from the top so the first set bit found
   // (the most significant one) decides the count.
   function automatic int count_lz(input logic [LZC_MAX_W-1:0] d, input int w);
      int   cnt;
      logic found;
      cnt   = w;
      found = 1'b0;
      for (int i = LZC_MAX_W - 1; i >= 0; i--) begin
         if ((i < w) && d[i] && !found) begin
            cnt   = w - 1 - i;
            found = 1'b1;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/fpu_lshifter.sv
// -----------------------------------------------------------------------------
// fpu_lshifter
// Combinational logarithmic left shifter. Zeros are shifted in at the bottom
// and bits shifted past the top are dropped.
//   data_i   [WIDTH-1:0]  value to shift
//   shamt_i  [SH_W-1:0]   left-shift amount
//   data_o   [WIDTH-1:0]  data_i << shamt_i, or 0 when shamt_i >= WIDTH
// -----------------------------------------------------------------------------
module fpu_lshifter
   import fpu_pkg::*;
#(
   parameter int WIDTH = FPU_WIDTH,
   parameter int SH_W  = FPU_SH_W
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [SH_W-1:0]  shamt_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int LOGW = $clog2(WIDTH);

   logic [WIDTH-1:0] stage [LOGW+1];

   assign stage[0] = data_i;

   // One mux level per shift-amount bit: level g shifts by 2**g.
   for (genvar g = 0; g < LOGW; g++) begin : g_level
      assign stage[g+1] = shamt_i[g] ? (stage[g] << (1 << g)) : stage[g];
   end

   // Any set bit at or above LOGW means the shift covers the whole word.
   assign data_o = (|shamt_i[SH_W-1:LOGW]) ? '0 : stage[LOGW];

endmodule

// File: rtl/fpu_lnormalizer.sv
// -----------------------------------------------------------------------------
// fpu_lnormalizer
// Two-stage pipelined left-shift normalizer. Counts leading zeros of the
// mantissa, shifts it left until the MSB is set and lowers the exponent by
// the same amount. If the exponent would go below 1 the shift is clamped and
// a denormal (exponent 0) result is produced.
//   clk, rst     clock and synchronous active-high reset
//   in_valid     input beat valid
//   in_ready     normalizer can take a beat this cycle
//   in_data      unnormalized mantissa
//   in_exp       biased exponent of in_data
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_data     normalized or denormal mantissa
//   out_exp      adjusted biased exponent
//   out_shamt    left shift actually applied
//   out_zero     in_data was all zeros
//   out_denorm   result is denormal
// -----------------------------------------------------------------------------
module fpu_lnormalizer
   import fpu_pkg::*;
#(
   parameter int WIDTH = FPU_WIDTH,
   parameter int EXP_W = FPU_EXP_W,
   parameter int SH_W  = FPU_SH_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [EXP_W-1:0] in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [EXP_W-1:0] out_exp,
   output logic [SH_W-1:0]  out_shamt,
   output logic             out_zero,
   output logic             out_denorm
);

   // Exponent and count are compared in a common width wide enough for both.
   localparam int XW = EXP_W + SH_W;

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_data_q;
   logic [EXP_W-1:0] s1_exp_q;
   logic [SH_W-1:0]  s1_lzc_q;
   logic [SH_W-1:0]  s1_lzc_d;

   logic             s2_valid_q;
   logic [WIDTH-1:0] s2_data_q;
   logic [EXP_W-1:0] s2_exp_q;
   logic [SH_W-1:0]  s2_shamt_q;
   logic             s2_zero_q;
   logic             s2_denorm_q;

   logic [WIDTH-1:0] s2_data_d;
   logic [EXP_W-1:0] s2_exp_d;
   logic [SH_W-1:0]  s2_shamt_d;
   logic             s2_zero_d;
   logic             s2_denorm_d;

   logic             s1_load;
   logic             s2_load;
   logic [XW-1:0]    e_ext;
   logic [XW-1:0]    l_ext;

   // Each stage advances when it is empty or the stage after it is moving,
   // so a full pipe still streams one beat per cycle.
   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   assign s1_lzc_d = SH_W'(count_lz(LZC_MAX_W'(in_data), WIDTH));

   // Stage 1 captures the raw operands and their leading-zero count.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_exp_q   <= '0;
         s1_lzc_q   <= '0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_data_q <= in_data;
            s1_exp_q  <= in_exp;
            s1_lzc_q  <= s1_lzc_d;
         end
      end
   end

   // Shift selection: normalize fully when the exponent can absorb the whole
   // count; otherwise stop at exponent 1 worth of shift and flag denormal.
   // An exponent of 0 is already denormal and is passed through unshifted.
   always_comb begin
      e_ext       = {{SH_W{1'b0}}, s1_exp_q};
      l_ext       = {{EXP_W{1'b0}}, s1_lzc_q};
      s2_shamt_d  = '0;
      s2_exp_d    = '0;
      s2_zero_d   = 1'b0;
      s2_denorm_d = 1'b0;
      if (s1_data_q == '0) begin
         s2_zero_d = 1'b1;
      end else if (e_ext > l_ext) begin
         s2_shamt_d = s1_lzc_q;
         s2_exp_d   = EXP_W'(e_ext - l_ext);
      end else if (s1_exp_q == '0) begin
         s2_denorm_d = 1'b1;
      end else begin
         s2_shamt_d  = SH_W'(e_ext - XW'(1));
         s2_denorm_d = 1'b1;
      end
   end

   fpu_lshifter #(
      .WIDTH (WIDTH),
      .SH_W  (SH_W)
   ) u_lshifter (
      .data_i  (s1_data_q),
      .shamt_i (s2_shamt_d),
      .data_o  (s2_data_d)
   );

   // Stage 2 holds the finished result; it only updates when the output side
   // is free, which keeps out_* stable during backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         s2_exp_q    <= '0;
         s2_shamt_q  <= '0;
         s2_zero_q   <= 1'b0;
         s2_denorm_q <= 1'b0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q   <= s2_data_d;
            s2_exp_q    <= s2_exp_d;
            s2_shamt_q  <= s2_shamt_d;
            s2_zero_q   <= s2_zero_d;
            s2_denorm_q <= s2_denorm_d;
         end
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_data   = s2_data_q;
   assign out_exp    = s2_exp_q;
   assign out_shamt  = s2_shamt_q;
   assign out_zero   = s2_zero_q;
   assign out_denorm = s2_denorm_q;

endmodule

// File: tb/tb_fpu_lnormalizer.sv
// -----------------------------------------------------------------------------
// tb_fpu_lnormalizer
// Self-checking bench for fpu_lnormalizer: directed cases, backpressure,
// mid-flight reset and a randomized stream against a reference model.
// -----------------------------------------------------------------------------
module tb_fpu_lnormalizer;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  expo;
      logic [5:0]  shamt;
      logic        zero;
      logic        denorm;
   } res_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [7:0]  in_exp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_exp;
   logic [5:0]  out_shamt;
   logic        out_zero;
   logic        out_denorm;

   int   total;
   int   bad;
   res_t expQ [$];
   logic stalledPrev;
   res_t held;
   int   outCount;

   fpu_lnormalizer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_exp     (in_exp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_exp    (out_exp),
      .out_shamt  (out_shamt),
      .out_zero   (out_zero),
      .out_denorm (out_denorm)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: normalize by plain integer arithmetic.
   function automatic res_t model(input logic [31:0] d, input logic [7:0] e);
      res_t r;
      int   lz;
      int   ee;
      int   sh;
      r  = '0;
      lz = 32;
      ee = int'(e);
      for (int i = 31; i >= 0; i--) begin
         if (d[i]) begin
            lz = 31 - i;
            break;
         end
      end
      if (d == 32'd0) begin
         r.zero = 1'b1;
         return r;
      end
      if (ee > lz) begin
         sh     = lz;
         r.expo = 8'(ee - lz);
      end else if (ee == 0) begin
         sh       = 0;
         r.denorm = 1'b1;
      end else begin
         sh       = ee - 1;
         r.denorm = 1'b1;
      end
      r.shamt = 6'(sh);
      r.data  = d << sh;
      return r;
   endfunction

   function automatic res_t observed();
      return {out_data, out_exp, out_shamt, out_zero, out_denorm};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   // One clock cycle with scoreboard bookkeeping. Called just after a falling
   // edge once inputs are set; sees the handshakes that will fire on the next
   // rising edge, then returns after the following falling edge.
   task automatic applyStimulus(output logic accepted);
      res_t r;
      #1;
      if (stalledPrev) begin
         checkOutput("stall_valid", 64'(out_valid), 64'd1);
         checkOutput("stall_hold", 64'(observed()), 64'(held));
      end
      if (out_valid && out_ready) begin
         outCount++;
         if (expQ.size() == 0) begin
            checkOutput("spurious_out", 64'(out_valid), 64'd0);
         end else begin
            r = expQ.pop_front();
            checkOutput("result", 64'(observed()), 64'(r));
         end
      end
      accepted = in_valid && in_ready;
      if (accepted) expQ.push_back(model(in_data, in_exp));
      stalledPrev = out_valid && !out_ready;
      held        = observed();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst         = 1'b0;
      stalledPrev = 1'b0;
      expQ.delete();
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_outputs", 64'(observed()), 64'd0);
   endtask

   // Single beat with a free output: checks latency and exact values.
   task automatic directed(input string tag, input logic [31:0] d, input logic [7:0] e,
                           input res_t req);
      logic acc;
      in_valid  = 1'b1;
      in_data   = d;
      in_exp    = e;
      out_ready = 1'b1;
      applyStimulus(acc);
      checkOutput({tag, "_accept"}, 64'(acc), 64'd1);
      in_valid = 1'b0;
      applyStimulus(acc);
      #1;
      checkOutput({tag, "_latency"}, 64'(out_valid), 64'd1);
      checkOutput(tag, 64'(observed()), 64'(req));
      applyStimulus(acc);
   endtask

   initial begin
      logic        acc;
      logic        sawFull;
      logic [31:0] beatD [4];
      logic [7:0]  beatE [4];
      int          sent;
      logic [31:0] curD;
      logic [7:0]  curE;
      int          accepted;

      total       = 0;
      bad         = 0;
      stalledPrev = 1'b0;
      outCount    = 0;
      in_data     = '0;
      in_exp      = '0;
      @(negedge clk);
      doReset();

      directed("basic",  32'h0000_1234, 8'd100, {32'h91A0_0000, 8'd81, 6'd19, 1'b0, 1'b0});
      directed("clamp",  32'h0000_1234, 8'd10,  {32'h0024_6800, 8'd0,  6'd9,  1'b0, 1'b1});
      directed("zero",   32'h0000_0000, 8'd50,  {32'h0000_0000, 8'd0,  6'd0,  1'b1, 1'b0});
      directed("normd",  32'h8000_0000, 8'd127, {32'h8000_0000, 8'd127, 6'd0, 1'b0, 1'b0});
      directed("exp0",   32'h0000_00F0, 8'd0,   {32'h0000_00F0, 8'd0,  6'd0,  1'b0, 1'b1});
      directed("exp1",   32'h0000_0001, 8'd1,   {32'h0000_0001, 8'd0,  6'd0,  1'b0, 1'b1});
      directed("lsb",    32'h0000_0001, 8'd200, {32'h8000_0000, 8'd169, 6'd31, 1'b0, 1'b0});
      directed("eq_lzc", 32'h0000_0001, 8'd31,  {32'h4000_0000, 8'd0,  6'd30, 1'b0, 1'b1});

      // Four back-to-back beats with the output stalled in cycles 2..6.
      beatD = '{32'h0000_0F00, 32'h0100_0000, 32'h0000_0003, 32'h7FFF_FFFF};
      beatE = '{8'd40, 8'd3, 8'd255, 8'd1};
      sent     = 0;
      sawFull  = 1'b0;
      outCount = 0;
      for (int c = 1; c <= 40 && (sent < 4 || expQ.size() > 0); c++) begin
         in_valid  = (sent < 4);
         in_data   = beatD[sent < 4 ? sent : 0];
         in_exp    = beatE[sent < 4 ? sent : 0];
         out_ready = !(c >= 2 && c <= 6);
         #1;
         if (in_valid && !in_ready) sawFull = 1'b1;
         applyStimulus(acc);
         if (acc) sent++;
      end
      in_valid = 1'b0;
      checkOutput("bp_in_ready_drop", 64'(sawFull), 64'd1);
      checkOutput("bp_out_count", 64'(outCount), 64'd4);
      checkOutput("bp_drained", 64'(expQ.size()), 64'd0);

      // Two beats in flight, then a one-cycle reset.
      in_valid  = 1'b1;
      in_data   = 32'h0000_ABCD;
      in_exp    = 8'd90;
      out_ready = 1'b1;
      applyStimulus(acc);
      in_data = 32'h0012_3456;
      in_exp  = 8'd5;
      applyStimulus(acc);
      #1;
      checkOutput("mid_pipe_full", 64'(out_valid), 64'd1);
      doReset();
      outCount  = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(acc);
         checkOutput("post_rst_no_out", 64'(out_valid), 64'd0);
      end
      checkOutput("post_rst_count", 64'(outCount), 64'd0);

      // Randomized stream with random backpressure.
      curD     = $urandom >> $urandom_range(0, 32);
      curE     = 8'($urandom_range(0, 255));
      accepted = 0;
      outCount = 0;
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7) && (accepted < 300);
         in_data   = curD;
         in_exp    = curE;
         out_ready = ($urandom_range(0, 9) < 7);
         applyStimulus(acc);
         if (acc) begin
            accepted++;
            curD = $urandom >> $urandom_range(0, 32);
            curE = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40))
                                               : 8'($urandom_range(0, 255));
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 100 && expQ.size() > 0; c++) applyStimulus(acc);
      checkOutput("rand_drained", 64'(expQ.size()), 64'd0);
      checkOutput("rand_count", 64'(outCount), 64'(accepted));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
